// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and BCD helper for the keypad adder.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] BLANK   = 4'hF;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_SUM = 2'b10
  } state_t;

  // Two-digit BCD operand, tens in d1.
  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd2_t;

  // Three-digit BCD result; the hundreds digit is at most 1.
  typedef struct packed {
    logic       s2;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_sum_t;

  // Digit-serial BCD add of two 00-99 operands.
  function automatic bcd_sum_t bcd_add(input bcd2_t a, input bcd2_t b);
    logic [4:0] t0;
    logic [4:0] t1;
    logic       c0;
    bcd_sum_t   r;
    t0 = {1'b0, a.d0} + {1'b0, b.d0};
    c0 = (t0 > 5'd9);
    r.s0 = c0 ? 4'(t0 - 5'd10) : t0[3:0];
    t1 = {1'b0, a.d1} + {1'b0, b.d1} + {4'b0, c0};
    r.s2 = (t1 > 5'd9);
    r.s1 = r.s2 ? 4'(t1 - 5'd10) : t1[3:0];
    return r;
  endfunction

endpackage

// File: rtl/keypad_add_ctrl_press_qualifier.sv
// Turns the raw pressed level into a single accept pulse per physical press.
// One counter is shared: while armed it counts high samples, while disarmed
// it counts low samples toward re-arming.
module press_qualifier #(
  parameter int DEB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pressed,
  input  logic [3:0] i_key,
  output logic       o_accept,
  output logic [3:0] o_key
);

  localparam logic [3:0] LAST = 4'(DEB_CYCLES - 1);

  logic [3:0] r_cnt;
  logic       r_armed;
  logic       w_hit;

  // The edge on which the high count reaches DEB_CYCLES is the accept edge;
  // the key is consumed on that same edge by the controller.
  assign w_hit    = r_armed && i_pressed && (r_cnt == LAST);
  assign o_accept = w_hit;
  assign o_key    = w_hit ? i_key : 4'h0;

  // High-run / low-run counter and arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_armed <= 1'b1;
    end else if (r_armed) begin
      if (!i_pressed) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= 4'd0;
        r_armed <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else begin
      if (i_pressed) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= 4'd0;
        r_armed <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_add_ctrl.sv
// Keypad adder controller: operand entry FSM, BCD sum latch and display mux.
module keypad_add_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pressed,
  input  logic [3:0]  key,
  output logic [15:0] disp,
  output logic        key_ack,
  output logic [1:0]  state,
  output logic        sum_valid
);

  logic       w_accept;
  logic [3:0] w_key;
  logic       w_digit;
  bcd_sum_t   w_sum;

  state_t     r_state;
  bcd2_t      r_a;
  bcd2_t      r_b;
  bcd_sum_t   r_sum;
  logic       r_key_ack;
  logic [15:0] w_disp;

  press_qualifier #(.DEB_CYCLES(DEB_CYCLES)) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pressed (pressed),
    .i_key     (key),
    .o_accept  (w_accept),
    .o_key     (w_key)
  );

  assign w_digit = (w_key <= 4'd9);
  assign w_sum   = bcd_add(r_a, r_b);

  // Entry FSM; every accepted key of a recognised class acks, others drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_A;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_key_ack <= 1'b0;
    end else begin
      r_key_ack <= 1'b0;
      case (r_state)
        S_A, S_B, S_SUM: begin
          if (w_accept) begin
            if (w_key == KEY_CLR) begin
              r_a       <= '0;
              r_b       <= '0;
              r_sum     <= '0;
              r_state   <= S_A;
              r_key_ack <= 1'b1;
            end else if (w_digit) begin
              r_key_ack <= 1'b1;
              if (r_state == S_A) begin
                r_a <= '{d1: r_a.d0, d0: w_key};
              end else if (r_state == S_B) begin
                r_b <= '{d1: r_b.d0, d0: w_key};
              end else begin
                r_a     <= '{d1: 4'h0, d0: w_key};
                r_b     <= '0;
                r_state <= S_A;
              end
            end else if (w_key == KEY_ADD && r_state == S_A) begin
              r_b       <= '0;
              r_state   <= S_B;
              r_key_ack <= 1'b1;
            end else if (w_key == KEY_EQ && r_state == S_B) begin
              r_sum     <= w_sum;
              r_state   <= S_SUM;
              r_key_ack <= 1'b1;
            end
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean operand-A entry.
          r_state <= S_A;
          r_a     <= '0;
          r_b     <= '0;
          r_sum   <= '0;
        end
      endcase
    end
  end

  // Display mux from registered state; hundreds digit blanked when zero.
  always_comb begin
    w_disp = {BLANK, BLANK, 8'h00};
    case (r_state)
      S_A:     w_disp = {BLANK, BLANK, r_a};
      S_B:     w_disp = {BLANK, BLANK, r_b};
      S_SUM:   w_disp = {BLANK, (r_sum.s2 ? 4'h1 : BLANK), r_sum.s1, r_sum.s0};
      default: w_disp = {BLANK, BLANK, 8'h00};
    endcase
  end

  assign disp      = w_disp;
  assign key_ack   = r_key_ack;
  assign state     = r_state;
  assign sum_valid = (r_state == S_SUM);

endmodule

// File: tb/tb_keypad_add_ctrl.sv
// Directed bench for keypad_add_ctrl with DEB_CYCLES=3.
module tb_keypad_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pressed;
  logic [3:0]  key;
  logic [15:0] disp;
  logic        key_ack;
  logic [1:0]  state;
  logic        sum_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int acks;
  int first;

  keypad_add_ctrl #(.DEB_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pressed   (pressed),
    .key       (key),
    .disp      (disp),
    .key_ack   (key_ack),
    .state     (state),
    .sum_valid (sum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge. Holds pressed high for hi rising edges, then
  // low for lo edges; samples key_ack at each following negedge.
  task automatic press(input logic [3:0] k, input int hi, input int lo,
                       output int n_ack, output int first_ack);
    n_ack = 0;
    first_ack = -1;
    pressed = 1'b1;
    key = k;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      if (key_ack === 1'b1) begin
        n_ack++;
        if (first_ack < 0) first_ack = i;
      end
      if (i == hi) pressed = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pressed = 1'b0;
    key = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (disp !== 16'hFF00 || state !== 2'd0 || key_ack !== 1'b0 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: disp=%h state=%0d ack=%b sv=%b, want FF00 0 0 0", disp, state, key_ack, sum_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (disp !== 16'hFF00 || state !== 2'd0 || key_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: disp=%h state=%0d ack=%b, want FF00 0 0", disp, state, key_ack);
    end
  endtask

  task automatic test_operand_a;
    press(4'd7, 3, 4, acks, first);
    n_checks++;
    // Accept on edge 3 (third high sample); ack visible in the 4th cycle.
    if (acks !== 1 || first !== 3) begin
      n_fail++;
      $display("FAIL a_first_ack: acks=%0d first=%0d, want 1 at 3", acks, first);
    end
    n_checks++;
    if (disp !== 16'hFF07) begin
      n_fail++;
      $display("FAIL a_digit7: disp=%h, want FF07", disp);
    end
    press(4'd4, 3, 4, acks, first);
    press(4'd2, 3, 4, acks, first);
    n_checks++;
    if (disp !== 16'hFF42 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL a_shift: disp=%h state=%0d, want FF42 0", disp, state);
    end
  endtask

  task automatic test_full_sum;
    press(4'hC, 3, 4, acks, first);
    press(4'd9, 3, 4, acks, first);
    press(4'd9, 3, 4, acks, first);
    press(4'hA, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || state !== 2'd1 || disp !== 16'hFF00) begin
      n_fail++;
      $display("FAIL sum_add: acks=%0d state=%0d disp=%h, want 1 1 FF00", acks, state, disp);
    end
    press(4'd9, 3, 4, acks, first);
    press(4'd9, 3, 4, acks, first);
    n_checks++;
    if (disp !== 16'hFF99) begin
      n_fail++;
      $display("FAIL sum_b99: disp=%h, want FF99", disp);
    end
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || state !== 2'd2 || sum_valid !== 1'b1 || disp !== 16'hF198) begin
      n_fail++;
      $display("FAIL sum_198: acks=%0d state=%0d sv=%b disp=%h, want 1 2 1 F198", acks, state, sum_valid, disp);
    end
    // 12 + 30 = 42, no carries, hundreds blank.
    press(4'hC, 3, 4, acks, first);
    press(4'd1, 3, 4, acks, first);
    press(4'd2, 3, 4, acks, first);
    press(4'hA, 3, 4, acks, first);
    press(4'd3, 3, 4, acks, first);
    press(4'd0, 3, 4, acks, first);
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (disp !== 16'hFF42 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL sum_42: disp=%h state=%0d, want FF42 2", disp, state);
    end
    // 45 + 55 = 100: both digit positions carry.
    press(4'hC, 3, 4, acks, first);
    press(4'd4, 3, 4, acks, first);
    press(4'd5, 3, 4, acks, first);
    press(4'hA, 3, 4, acks, first);
    press(4'd5, 3, 4, acks, first);
    press(4'd5, 3, 4, acks, first);
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (disp !== 16'hF100) begin
      n_fail++;
      $display("FAIL sum_100: disp=%h, want F100", disp);
    end
  endtask

  task automatic test_glitch_hold;
    press(4'hC, 3, 4, acks, first);
    press(4'd5, 2, 4, acks, first);
    n_checks++;
    if (acks !== 0 || disp !== 16'hFF00) begin
      n_fail++;
      $display("FAIL glitch: acks=%0d disp=%h, want 0 FF00", acks, disp);
    end
    press(4'd5, 50, 4, acks, first);
    n_checks++;
    if (acks !== 1 || disp !== 16'hFF05) begin
      n_fail++;
      $display("FAIL hold50: acks=%0d disp=%h, want 1 FF05", acks, disp);
    end
    press(4'd3, 3, 2, acks, first);
    n_checks++;
    if (acks !== 1 || disp !== 16'hFF53) begin
      n_fail++;
      $display("FAIL press3: acks=%0d disp=%h, want 1 FF53", acks, disp);
    end
    // Only two low cycles since release: still disarmed.
    press(4'd4, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || disp !== 16'hFF53) begin
      n_fail++;
      $display("FAIL early_repress: acks=%0d disp=%h, want 0 FF53", acks, disp);
    end
    press(4'd4, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || disp !== 16'hFF34) begin
      n_fail++;
      $display("FAIL rearmed: acks=%0d disp=%h, want 1 FF34", acks, disp);
    end
  endtask

  task automatic test_ignored;
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || state !== 2'd0 || disp !== 16'hFF34) begin
      n_fail++;
      $display("FAIL eq_in_a: acks=%0d state=%0d disp=%h, want 0 0 FF34", acks, state, disp);
    end
    press(4'hB, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || state !== 2'd0 || disp !== 16'hFF34) begin
      n_fail++;
      $display("FAIL code_b: acks=%0d state=%0d disp=%h, want 0 0 FF34", acks, state, disp);
    end
    press(4'hA, 3, 4, acks, first);
    press(4'hA, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || state !== 2'd1 || disp !== 16'hFF00) begin
      n_fail++;
      $display("FAIL add_in_b: acks=%0d state=%0d disp=%h, want 0 1 FF00", acks, state, disp);
    end
    press(4'd1, 3, 4, acks, first);
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (state !== 2'd2 || disp !== 16'hFF35) begin
      n_fail++;
      $display("FAIL sum_35: state=%0d disp=%h, want 2 FF35", state, disp);
    end
    press(4'hA, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || state !== 2'd2 || disp !== 16'hFF35) begin
      n_fail++;
      $display("FAIL add_in_sum: acks=%0d state=%0d disp=%h, want 0 2 FF35", acks, state, disp);
    end
    press(4'hE, 3, 4, acks, first);
    n_checks++;
    if (acks !== 0 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL eq_in_sum: acks=%0d state=%0d, want 0 2", acks, state);
    end
    press(4'd5, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || state !== 2'd0 || disp !== 16'hFF05 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL digit_in_sum: acks=%0d state=%0d disp=%h sv=%b, want 1 0 FF05 0", acks, state, disp, sum_valid);
    end
  endtask

  task automatic test_clear_reset;
    press(4'hA, 3, 4, acks, first);
    press(4'd8, 3, 4, acks, first);
    n_checks++;
    if (state !== 2'd1 || disp !== 16'hFF08) begin
      n_fail++;
      $display("FAIL b_entry: state=%0d disp=%h, want 1 FF08", state, disp);
    end
    press(4'hC, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || state !== 2'd0 || disp !== 16'hFF00) begin
      n_fail++;
      $display("FAIL clear_b: acks=%0d state=%0d disp=%h, want 1 0 FF00", acks, state, disp);
    end
    press(4'd7, 3, 4, acks, first);
    // Two high samples (counter at 2), then reset between edges.
    pressed = 1'b1;
    key = 4'd9;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (disp !== 16'hFF00 || state !== 2'd0 || key_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: disp=%h state=%0d ack=%b, want FF00 0 0", disp, state, key_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Still high: counter restarted, so two more edges must not accept.
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (key_ack === 1'b1) acks++;
    end
    pressed = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (key_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0 || disp !== 16'hFF00) begin
      n_fail++;
      $display("FAIL post_reset_short: acks=%0d disp=%h, want 0 FF00", acks, disp);
    end
    press(4'd9, 3, 4, acks, first);
    n_checks++;
    if (acks !== 1 || first !== 3 || disp !== 16'hFF09) begin
      n_fail++;
      $display("FAIL post_reset_press: acks=%0d first=%0d disp=%h, want 1 3 FF09", acks, first, disp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pressed = 1'b0;
    key = 4'h0;
    test_reset();
    test_operand_a();
    test_full_sum();
    test_glitch_hold();
    test_ignored();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
